stage_ex_unit: RTL
==================

// Module: stage_ex_unit
// PURPOSE
// - Execute stage: consumes the ID->EX pipeline register outputs, computes Val2, runs the ALU, owns the NZCV status register.
// - Resolves branches (branch_taken, branch_addr back to IF) and feeds status to ID for condition checks.
// - Ends in the EX->MEM pipeline register.
// PARAMETERS
// - XLEN        32  datapath width; only 32 is supported
// - RST_PC_ZERO 1   reserved; must stay 1
// PORTS
// clk               in   1   rising-edge clock
// rst               in   1   asynchronous reset, active-low
// pc_in             in   32  PC+4 of the instruction in EX
// reg1_in           in   32  Rn value
// reg2_in           in   32  Rm / Rd (store) value
// exe_cmd_in        in   4   ALU command
// mem_read_in       in   1   LDR
// mem_write_in      in   1   STR
// wb_en_in          in   1   register write-back enable
// b_in              in   1   branch instruction
// s_in              in   1   update status
// imm_in            in   1   I bit
// shift_operand_in  in   12  shifter operand field
// imm24_in          in   24  signed branch offset (words)
// dest_in           in   4   Rd
// branch_taken      out  1   comb: equals b_in
// branch_addr       out  32  comb: pc_in + (sext(imm24_in) << 2), mod 2^32
// status            out  4   registered {N,Z,C,V}
// alu_result_out    out  32  registered ALU result
// st_val_out        out  32  registered reg2_in (store data)
// dest_out          out  4   registered dest_in
// mem_read_out      out  1   registered mem_read_in
// mem_write_out     out  1   registered mem_write_in
// wb_en_out         out  1   registered wb_en_in
// BEHAVIOUR
// - Reset (rst=0, async): status=0, all *_out regs=0. Combinational outputs follow their inputs during reset.
// - Latency: every registered output is 1 cycle. The EX->MEM register captures on every rising edge; it has no freeze or flush.
// - Val2 selection:
//   - mem op (mem_read_in|mem_write_in): {20'b0, shift_operand_in}.
//   - imm_in=1: {24'b0, so[7:0]} rotated right by 2*so[11:8].
//   - imm_in=0, so[4]=0: reg2_in shifted by so[11:7], type so[6:5] = 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes the value through.
//   - so[4]=1 (register shift): unsupported; Val2 = reg2_in.
// - ALU, A = reg1_in, B = Val2, Cin = status.C:
//   - 0001 MOV B; 1001 MVN ~B
//   - 0010 ADD A+B; 0011 ADC A+B+Cin
//   - 0100 SUB/CMP A-B; 0101 SBC A-B-~Cin
//   - 0110 AND/TST A&B; 0111 ORR; 1000 EOR
//   - any other code: result 0, flags unchanged.
// - Flags:
//   - N = res[31]; Z = (res == 0).
//   - Add ops: C = carry out of bit 31; V = (A31 == B31) && (res31 != A31).
//   - Sub ops: C = NOT borrow; V = (A31 != B31) && (res31 != A31).
//   - MOV/MVN/logic ops: C and V are held.
// - Status write: on a clock edge with s_in=1 && b_in=0, status <= {N,Z,C,V}; otherwise status holds.
// - Branch: branch_taken is high in the same cycle b_in is high; the ALU result is don't-care.
// - Condition gating is done in ID: an instruction that fails its condition arrives with wb_en/mem/s/b all 0.
// - Reset mid-operation: the pipeline register and status clear immediately; there is no partial update.
// STRUCTURE
// - Shared package arm_pkg: EXE_* 4-bit command constants, SHIFT_* type codes, status bit indices N=3, Z=2, C=1, V=0.
// - Sub-module alu (combinational: A, B, cmd, cin -> res, n, z, c, v).
// - Val2 generator, branch adder, status register and EX->MEM register stay inline.
// TESTING
// - Reset: rst=0 mid-run -> status=0 and all *_out=0 without waiting for a clock edge; they stay 0 while rst=0.
// - ADDS 0x7FFFFFFF+1 (cmd 0010, s=1) -> alu_result_out=0x80000000 next cycle, status=1001 (N,V).
// - SUBS 5-5 -> result 0, status=0110 (Z,C); then ADC 1+1 -> result 3 (Cin=1), status unchanged because s=0.
// - Val2: imm_in=1, so=0x2FF -> B=0xF000000F; imm_in=0, so=0x0C2 (ASR #1), reg2=0x80000004 -> B=0xC0000002.
// - Branch: b_in=1, pc_in=0x100, imm24=0xFFFFFE -> branch_taken=1, branch_addr=0xF8 in the same cycle; status unchanged even with s_in=1.
// - STR: mem_write_in=1, reg1=0x40, so=0x008, reg2=0xDEAD -> alu_result_out=0x48, st_val_out=0xDEAD, mem_write_out=1.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared execute-stage definitions: ALU command codes, shifter types,
// status bit positions and the EX->MEM register layout.
package arm_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] st_val;
        logic [3:0]  dest;
        logic        mem_read;
        logic        mem_write;
        logic        wb_en;
    } ex_mem_t;

    // A rotate amount of 0 yields v unchanged: the left shift by 32 is all zeros.
    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
        return (v >> amt) | (v << (6'd32 - {1'b0, amt}));
    endfunction

endpackage

// File: rtl/stage_ex_unit_alu.sv
// Combinational ALU: result plus NZCV; C/V pass through for non-arithmetic ops
// and valid drops for unrecognised commands so the caller can hold status.
module alu
    import arm_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  cmd,
    input  logic        cin,
    input  logic        vin,
    output logic [31:0] res,
    output logic        n,
    output logic        z,
    output logic        c,
    output logic        v,
    output logic        valid
);

    logic [32:0] sum;

    always_comb begin
        sum   = '0;
        res   = '0;
        c     = cin;
        v     = vin;
        valid = 1'b1;
        case (cmd)
            EXE_MOV: res = b;
            EXE_MVN: res = ~b;
            EXE_ADD, EXE_ADC: begin
                sum = {1'b0, a} + {1'b0, b} + {32'b0, (cmd == EXE_ADC) & cin};
                res = sum[31:0];
                c   = sum[32];
                v   = (a[31] == b[31]) && (res[31] != a[31]);
            end
            // bit 32 of the 33-bit difference is the borrow
            EXE_SUB, EXE_SBC: begin
                sum = {1'b0, a} - {1'b0, b} - {32'b0, (cmd == EXE_SBC) & ~cin};
                res = sum[31:0];
                c   = ~sum[32];
                v   = (a[31] != b[31]) && (res[31] != a[31]);
            end
            EXE_AND: res = a & b;
            EXE_ORR: res = a | b;
            EXE_EOR: res = a ^ b;
            default: valid = 1'b0;
        endcase
    end

    assign n = res[31];
    assign z = (res == 32'd0);

endmodule

// File: rtl/stage_ex_unit.sv
// Execute stage: Val2 generation, ALU, NZCV status register, branch target
// adder and the EX->MEM pipeline register.
module stage_ex_unit
    import arm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit RST_PC_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] reg1_in,
    input  logic [31:0] reg2_in,
    input  logic [3:0]  exe_cmd_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        wb_en_in,
    input  logic        b_in,
    input  logic        s_in,
    input  logic        imm_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] imm24_in,
    input  logic [3:0]  dest_in,
    output logic        branch_taken,
    output logic [31:0] branch_addr,
    output logic [3:0]  status,
    output logic [31:0] alu_result_out,
    output logic [31:0] st_val_out,
    output logic [3:0]  dest_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        wb_en_out
);

    if (XLEN != 32 || !RST_PC_ZERO) begin : g_bad_cfg
        $error("stage_ex_unit supports only XLEN=32 and RST_PC_ZERO=1");
    end

    logic [31:0] val2;
    logic [31:0] alu_res;
    logic        alu_n, alu_z, alu_c, alu_v, alu_valid;
    logic [3:0]  status_d, status_q;
    ex_mem_t     ex_mem_d, ex_mem_q;

    always_comb begin
        val2 = reg2_in;
        if (mem_read_in || mem_write_in) begin
            val2 = {20'b0, shift_operand_in};
        end else if (imm_in) begin
            val2 = ror32({24'b0, shift_operand_in[7:0]}, {shift_operand_in[11:8], 1'b0});
        end else if (!shift_operand_in[4]) begin
            case (shift_operand_in[6:5])
                SHIFT_LSL: val2 = reg2_in << shift_operand_in[11:7];
                SHIFT_LSR: val2 = reg2_in >> shift_operand_in[11:7];
                SHIFT_ASR: val2 = $signed(reg2_in) >>> shift_operand_in[11:7];
                SHIFT_ROR: val2 = ror32(reg2_in, shift_operand_in[11:7]);
                default:   val2 = reg2_in;
            endcase
        end
    end

    alu u_alu (
        .a     (reg1_in),
        .b     (val2),
        .cmd   (exe_cmd_in),
        .cin   (status_q[ST_C]),
        .vin   (status_q[ST_V]),
        .res   (alu_res),
        .n     (alu_n),
        .z     (alu_z),
        .c     (alu_c),
        .v     (alu_v),
        .valid (alu_valid)
    );

    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{6{imm24_in[23]}}, imm24_in, 2'b00};

    always_comb begin
        status_d = status_q;
        if (s_in && !b_in && alu_valid) begin
            status_d[ST_N] = alu_n;
            status_d[ST_Z] = alu_z;
            status_d[ST_C] = alu_c;
            status_d[ST_V] = alu_v;
        end
        ex_mem_d.alu_result = alu_res;
        ex_mem_d.st_val     = reg2_in;
        ex_mem_d.dest       = dest_in;
        ex_mem_d.mem_read   = mem_read_in;
        ex_mem_d.mem_write  = mem_write_in;
        ex_mem_d.wb_en      = wb_en_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= '0;
            ex_mem_q <= '0;
        end else begin
            status_q <= status_d;
            ex_mem_q <= ex_mem_d;
        end
    end

    assign status         = status_q;
    assign alu_result_out = ex_mem_q.alu_result;
    assign st_val_out     = ex_mem_q.st_val;
    assign dest_out       = ex_mem_q.dest;
    assign mem_read_out   = ex_mem_q.mem_read;
    assign mem_write_out  = ex_mem_q.mem_write;
    assign wb_en_out      = ex_mem_q.wb_en;

endmodule
